// File: rtl/ddr_pkt_streamer.sv
// Reads a length header plus payload words from a word-addressed memory port and
// streams them byte by byte into the TSE TX FIFO, with backpressure and status pulses.
module ddr_pkt_streamer #(
   parameter int DATA_W        = 256,
   parameter int ADDR_W        = 25,
   parameter int LEN_W         = 11,
   parameter int MAX_PKT_BYTES = 1518,
   parameter int LANE_SWAP     = 1
) (
   input  logic              clk_original,
   input  logic              rst,
   input  logic              cmd_send,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_ack,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [7:0]        ff_tx_data,
   output logic              ff_tx_sop,
   output logic              ff_tx_eop,
   output logic              ff_tx_wren,
   output logic              ff_tx_err,
   input  logic              ff_tx_rdy,
   output logic [2:0]        state_dbg
);

   localparam int BPW   = DATA_W / 8;
   localparam int IDX_W = $clog2(BPW);
   localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W+1)'(MAX_PKT_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HDR_REQ  = 3'd1,
      S_HDR_WAIT = 3'd2,
      S_DAT_REQ  = 3'd3,
      S_DAT_WAIT = 3'd4,
      S_STREAM   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    sent_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   word_q;
   logic                done_q;
   logic                err_q;
   logic [7:0]          lane_byte [BPW];

   // Handshakes: a memory request completes on the cycle mem_rd_req & mem_rd_ack, its data
   // arrives later with mem_rd_valid; a TX byte moves on the cycle ff_tx_wren & ff_tx_rdy and
   // everything driven towards the FIFO is held unchanged until then.
   logic [LEN_W-1:0] hdr_len;
   logic             len_bad;
   logic             xfer;
   logic             last_byte;
   logic             last_in_word;

   assign hdr_len      = mem_rd_data[LEN_W-1:0];
   assign len_bad      = (hdr_len == '0) || ({1'b0, hdr_len} > MAX_LEN);
   assign xfer         = (state_q == S_STREAM) && ff_tx_rdy;
   assign last_byte    = (sent_q == len_q - 1'b1);
   assign last_in_word = (idx_q == LAST_IDX);

   for (genvar k = 0; k < BPW; k++) begin : g_lane
      if (LANE_SWAP != 0) begin : g_swap
         assign lane_byte[k] = word_q[32*(k/4) + 31 - 8*(k%4) -: 8];
      end else begin : g_flat
         assign lane_byte[k] = word_q[8*k +: 8];
      end
   end

   always_ff @(posedge clk_original) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      busy        = (state_q != S_IDLE);
      mem_rd_req  = 1'b0;
      mem_rd_addr = '0;
      ff_tx_wren  = 1'b0;
      ff_tx_data  = '0;
      ff_tx_sop   = 1'b0;
      ff_tx_eop   = 1'b0;
      ff_tx_err   = 1'b0;
      done        = done_q;
      err_len     = err_q;
      state_dbg   = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_send) state_d = S_HDR_REQ;
         end
         S_HDR_REQ: begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = addr_q;
            if (mem_rd_ack) state_d = S_HDR_WAIT;
         end
         S_HDR_WAIT: begin
            if (mem_rd_valid) state_d = len_bad ? S_IDLE : S_DAT_REQ;
         end
         S_DAT_REQ: begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = addr_q;
            if (mem_rd_ack) state_d = S_DAT_WAIT;
         end
         S_DAT_WAIT: begin
            if (mem_rd_valid) state_d = S_STREAM;
         end
         S_STREAM: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = lane_byte[idx_q];
            ff_tx_sop  = (sent_q == '0);
            ff_tx_eop  = last_byte;
            if (xfer) begin
               if (last_byte)         state_d = S_IDLE;
               else if (last_in_word) state_d = S_DAT_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_original) begin
      if (rst) begin
         addr_q <= '0;
         len_q  <= '0;
         sent_q <= '0;
         idx_q  <= '0;
         word_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= xfer && last_byte;
         err_q  <= (state_q == S_HDR_WAIT) && mem_rd_valid && len_bad;
         case (state_q)
            S_IDLE: begin
               if (cmd_send) addr_q <= cmd_addr;
            end
            S_HDR_WAIT: begin
               if (mem_rd_valid) begin
                  len_q  <= hdr_len;
                  sent_q <= '0;
                  if (!len_bad) addr_q <= addr_q + 1'b1;
               end
            end
            S_DAT_WAIT: begin
               if (mem_rd_valid) begin
                  word_q <= mem_rd_data;
                  idx_q  <= '0;
               end
            end
            S_STREAM: begin
               if (xfer) begin
                  sent_q <= sent_q + 1'b1;
                  idx_q  <= idx_q + 1'b1;
                  // Refill address advances only when more payload is still needed.
                  if (last_in_word && !last_byte) addr_q <= addr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_pkt_streamer.sv
// Directed bench for ddr_pkt_streamer: a memory responder model, a TX byte monitor and
// one task per scenario comparing the captured stream against an expected queue.
module tb_ddr_pkt_streamer;

   localparam int DW = 256;
   localparam int AW = 25;

   logic clk_original = 1'b0;
   always #5 clk_original = ~clk_original;

   logic rst = 1'b1;

   // DUT A: LANE_SWAP=1
   logic          cmd_send = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic          busy, done, err_len, req, ack, wren, sop, eop, txerr;
   logic          valid = 1'b0;
   logic          rdy = 1'b1;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = '0;
   logic [7:0]    txd;
   logic [2:0]    st;

   // DUT B: LANE_SWAP=0
   logic          cmd_send_b = 1'b0;
   logic [AW-1:0] cmd_addr_b = '0;
   logic          busy_b, done_b, err_len_b, req_b, ack_b, wren_b, sop_b, eop_b, txerr_b;
   logic          valid_b = 1'b0;
   logic          rdy_b = 1'b1;
   logic [AW-1:0] raddr_b;
   logic [DW-1:0] rdata_b = '0;
   logic [7:0]    txd_b;
   logic [2:0]    st_b;

   assign ack   = req;
   assign ack_b = req_b;

   ddr_pkt_streamer #(.LANE_SWAP(1)) u_dut (
      .clk_original(clk_original), .rst(rst), .cmd_send(cmd_send), .cmd_addr(cmd_addr),
      .busy(busy), .done(done), .err_len(err_len), .mem_rd_req(req), .mem_rd_addr(raddr),
      .mem_rd_ack(ack), .mem_rd_valid(valid), .mem_rd_data(rdata), .ff_tx_data(txd),
      .ff_tx_sop(sop), .ff_tx_eop(eop), .ff_tx_wren(wren), .ff_tx_err(txerr),
      .ff_tx_rdy(rdy), .state_dbg(st)
   );

   ddr_pkt_streamer #(.LANE_SWAP(0)) u_dut_b (
      .clk_original(clk_original), .rst(rst), .cmd_send(cmd_send_b), .cmd_addr(cmd_addr_b),
      .busy(busy_b), .done(done_b), .err_len(err_len_b), .mem_rd_req(req_b),
      .mem_rd_addr(raddr_b), .mem_rd_ack(ack_b), .mem_rd_valid(valid_b),
      .mem_rd_data(rdata_b), .ff_tx_data(txd_b), .ff_tx_sop(sop_b), .ff_tx_eop(eop_b),
      .ff_tx_wren(wren_b), .ff_tx_err(txerr_b), .ff_tx_rdy(rdy_b), .state_dbg(st_b)
   );

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] rd_q[$];
   logic [9:0]    exp_q[$];
   logic [9:0]    got_q[$];
   logic [9:0]    got_b_q[$];
   int done_cnt = 0, err_cnt = 0, wren_cyc = 0, done_b_cnt = 0;

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return '0;
   endfunction

   // Memory responder: accepts every request at once, data one cycle later.
   always @(posedge clk_original) begin
      if (rst) valid <= 1'b0;
      else begin
         valid <= req && ack;
         if (req && ack) begin
            rdata <= mem_rd(raddr);
            rd_q.push_back(raddr);
         end
      end
   end

   always @(posedge clk_original) begin
      if (rst) valid_b <= 1'b0;
      else begin
         valid_b <= req_b && ack_b;
         if (req_b && ack_b) rdata_b <= mem_rd(raddr_b);
      end
   end

   // TX monitor: sampled mid-cycle; wren & rdy here means the byte moves on the next edge.
   always @(negedge clk_original) begin
      if (!rst) begin
         if (wren && rdy) got_q.push_back({sop, eop, txd});
         if (done) done_cnt++;
         if (err_len) err_cnt++;
         if (wren) wren_cyc++;
         if (wren_b && rdy_b) got_b_q.push_back({sop_b, eop_b, txd_b});
         if (done_b) done_b_cnt++;
      end
   end

   // Byte k of a payload word sits MSB-first within its 32-bit lane.
   function automatic logic [DW-1:0] make_word(input int base);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < DW/8; k++) w[32*(k/4) + 31 - 8*(k%4) -: 8] = 8'(base + k);
      return w;
   endfunction

   task automatic load_pkt(input logic [AW-1:0] hdr, input int len, input int base);
      logic [AW-1:0] a;
      mem[hdr] = (DW'(32'hBEEF) << 16) | DW'(len);
      for (int w = 0; w < (len + 31) / 32; w++) begin
         a = hdr + AW'(w + 1);
         mem[a] = make_word(base + 32*w);
      end
      exp_q.delete();
      for (int k = 0; k < len; k++) exp_q.push_back({(k == 0), (k == len - 1), 8'(base + k)});
      got_q.delete();
      rd_q.delete();
   endtask

   function automatic int first_diff();
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return -2;
      return -1;
   endfunction

   task automatic send_cmd(input logic [AW-1:0] a);
      @(posedge clk_original); #1;
      cmd_send = 1'b1;
      cmd_addr = a;
      @(posedge clk_original); #1;
      cmd_send = 1'b0;
   endtask

   task automatic wait_end(input int d0, input int e0, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk_original);
         if (done_cnt != d0 || err_cnt != e0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk_original);
      @(negedge clk_original);
      checks++;
      if ({busy, done, err_len, req, wren, sop, eop, txerr} !== 8'h00) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000000", {busy, done, err_len, req, wren, sop, eop, txerr});
      end
      checks++;
      if (raddr !== '0 || txd !== 8'h00) begin
         failures++;
         $display("FAIL reset_buses addr=%h data=%h exp=0", raddr, txd);
      end
      checks++;
      if (st !== 3'd0 || st_b !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d/%0d exp=0", st, st_b);
      end
      @(posedge clk_original); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit to;
      int d0, d;
      load_pkt(25'h10, 60, 0);
      d0 = done_cnt;
      checks++;
      if (req !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle_req got=%b exp=0", req);
      end
      send_cmd(25'h10);
      checks++;
      if (req !== 1'b1 || raddr !== 25'h10) begin
         failures++;
         $display("FAIL basic_req_latency req=%b addr=%h exp=1/10", req, raddr);
      end
      wait_end(d0, err_cnt, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL basic_timeout no done within budget");
      end
      repeat (2) @(negedge clk_original);
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL basic_bytes idx=%0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (rd_q.size() != 3 || rd_q[0] !== 25'h10 || rd_q[1] !== 25'h11 || rd_q[2] !== 25'h12) begin
         failures++;
         $display("FAIL basic_reads got_n=%0d exp=10,11,12", rd_q.size());
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL basic_done got=%0d exp=1", done_cnt - d0);
      end
   endtask

   task automatic test_single();
      bit to;
      int d0;
      load_pkt(25'h30, 1, 'hA0);
      d0 = done_cnt;
      send_cmd(25'h30);
      wait_end(d0, err_cnt, to);
      repeat (2) @(negedge clk_original);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== {2'b11, 8'hA0}) begin
         failures++;
         $display("FAIL single_swap1 n=%0d got=%h exp=3a0", got_q.size(), got_q[0]);
      end
      // Lane 0 of this word holds A0..A3 MSB-first, so word[7:0] is A3.
      got_b_q.delete();
      d0 = done_b_cnt;
      @(posedge clk_original); #1;
      cmd_send_b = 1'b1;
      cmd_addr_b = 25'h30;
      @(posedge clk_original); #1;
      cmd_send_b = 1'b0;
      for (int i = 0; i < 200 && done_b_cnt == d0; i++) @(negedge clk_original);
      checks++;
      if (done_b_cnt - d0 != 1 || got_b_q.size() != 1 || got_b_q[0] !== {2'b11, 8'hA3}) begin
         failures++;
         $display("FAIL single_swap0 n=%0d got=%h exp=3a3", got_b_q.size(), got_b_q[0]);
      end
   endtask

   task automatic test_backpressure();
      int d0, d, stalls;
      bit prev_stall, fin;
      logic [10:0] prev_out;
      load_pkt(25'h40, 64, 'h40);
      d0 = done_cnt;
      stalls = 0;
      prev_stall = 1'b0;
      fin = 1'b0;
      prev_out = '0;
      send_cmd(25'h40);
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(posedge clk_original); #1;
         rdy = ~rdy;
         @(negedge clk_original);
         if (prev_stall) begin
            stalls++;
            checks++;
            if ({wren, sop, eop, txd} !== prev_out) begin
               failures++;
               $display("FAIL bp_hold got=%h exp=%h", {wren, sop, eop, txd}, prev_out);
            end
         end
         prev_stall = wren && !rdy;
         prev_out = {wren, sop, eop, txd};
         fin = (done_cnt != d0);
      end
      rdy = 1'b1;
      repeat (2) @(negedge clk_original);
      checks++;
      if (!fin || stalls < 30) begin
         failures++;
         $display("FAIL bp_progress done=%b stalls=%0d exp_min=30", fin, stalls);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL bp_bytes idx=%0d got_n=%0d exp_n=64", d, got_q.size());
      end
      checks++;
      if (rd_q.size() != 3 || rd_q[2] !== 25'h42) begin
         failures++;
         $display("FAIL bp_reads got_n=%0d exp=3", rd_q.size());
      end
   endtask

   task automatic test_len_err();
      bit to;
      int d0, e0, w0, d;
      int bad_len [2] = '{0, 1519};
      logic [AW-1:0] bad_hdr [2] = '{25'h80, 25'h90};
      for (int t = 0; t < 2; t++) begin
         load_pkt(bad_hdr[t], bad_len[t], 0);
         d0 = done_cnt; e0 = err_cnt; w0 = wren_cyc;
         send_cmd(bad_hdr[t]);
         wait_end(d0, e0, to);
         repeat (2) @(negedge clk_original);
         checks++;
         if (to || err_cnt - e0 != 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL len_err len=%0d err=%0d done=%0d exp=1/0", bad_len[t], err_cnt - e0, done_cnt - d0);
         end
         checks++;
         if (wren_cyc != w0 || busy !== 1'b0 || rd_q.size() != 1) begin
            failures++;
            $display("FAIL len_err_quiet len=%0d wren=%0d busy=%b reads=%0d exp=0/0/1", bad_len[t], wren_cyc - w0, busy, rd_q.size());
         end
      end
      load_pkt(25'h1000, 1518, 7);
      d0 = done_cnt; e0 = err_cnt;
      send_cmd(25'h1000);
      wait_end(d0, e0, to);
      repeat (2) @(negedge clk_original);
      d = first_diff();
      checks++;
      if (to || d != -1 || err_cnt != e0 || rd_q.size() != 49) begin
         failures++;
         $display("FAIL len_max idx=%0d n=%0d reads=%0d exp=-1/1518/49", d, got_q.size(), rd_q.size());
      end
   endtask

   task automatic test_cmd_ignore_and_reset();
      bit to;
      int d0, d, eops;
      load_pkt(25'h200, 60, 'h10);
      d0 = done_cnt;
      send_cmd(25'h200);
      for (int i = 0; i < 500 && got_q.size() < 10; i++) @(negedge clk_original);
      send_cmd(25'h300);
      wait_end(d0, err_cnt, to);
      repeat (3) @(negedge clk_original);
      d = first_diff();
      checks++;
      if (to || d != -1 || done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL ignore_bytes idx=%0d done=%0d exp=-1/1", d, done_cnt - d0);
      end
      checks++;
      if (busy !== 1'b0 || rd_q.size() != 3 || rd_q[2] !== 25'h202) begin
         failures++;
         $display("FAIL ignore_cmd busy=%b reads=%0d exp=0/3", busy, rd_q.size());
      end
      got_q.delete();
      d0 = done_cnt;
      send_cmd(25'h200);
      for (int i = 0; i < 500 && got_q.size() < 20; i++) @(negedge clk_original);
      rst = 1'b1;
      @(posedge clk_original);
      @(negedge clk_original);
      checks++;
      if ({busy, done, err_len, req, wren, sop, eop, txerr} !== 8'h00 || txd !== 8'h00 || raddr !== '0 || st !== 3'd0) begin
         failures++;
         $display("FAIL abort_outputs flags=%b data=%h addr=%h st=%0d exp=0", {busy, done, err_len, req, wren, sop, eop, txerr}, txd, raddr, st);
      end
      @(posedge clk_original); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk_original);
      eops = 0;
      foreach (got_q[i]) if (got_q[i][8]) eops++;
      checks++;
      if (eops != 0 || done_cnt != d0 || busy !== 1'b0 || got_q.size() < 20) begin
         failures++;
         $display("FAIL abort_clean eops=%0d done=%0d busy=%b n=%0d exp=0/0/0/>=20", eops, done_cnt - d0, busy, got_q.size());
      end
   endtask

   task automatic test_addr_wrap();
      bit to;
      int d0, d;
      load_pkt(25'h1FFFFFF, 40, 'h33);
      d0 = done_cnt;
      send_cmd(25'h1FFFFFF);
      wait_end(d0, err_cnt, to);
      repeat (2) @(negedge clk_original);
      checks++;
      if (to || rd_q.size() != 3 || rd_q[0] !== 25'h1FFFFFF || rd_q[1] !== 25'h0 || rd_q[2] !== 25'h1) begin
         failures++;
         $display("FAIL wrap_reads n=%0d r1=%h r2=%h exp=3/0/1", rd_q.size(), rd_q[1], rd_q[2]);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL wrap_bytes idx=%0d got_n=%0d exp_n=40", d, got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_backpressure();
      test_len_err();
      test_cmd_ignore_and_reset();
      test_addr_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
